// File: rtl/spi16_master_tx_if.sv
// Word handshake plus SPI pins between the fabric and a spi16_master_tx.
interface spi16_master_tx_if;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        spi_cs;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;

   modport master (
      input  tx_data, tx_valid, spi_miso,
      output tx_ready, busy, rx_data, rx_valid, spi_cs, spi_sck, spi_mosi
   );

   modport slave (
      output tx_data, tx_valid, spi_miso,
      input  tx_ready, busy, rx_data, rx_valid, spi_cs, spi_sck, spi_mosi
   );
endinterface

// File: rtl/spi16_master_tx.sv
// 16-bit SPI mode-0 initiator, MSB first; optional MISO capture via SPI16_MASTER_TX_RX_EN.
// Latency: cs falls 1 cycle after accept, cs low 34*CLK_DIV cycles, accept-to-accept 34*CLK_DIV+CS_GAP+2.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored.
module spi16_master_tx #(
   parameter int CLK_DIV = 12,
   parameter int CS_GAP  = 8
) (
   input  logic               clk,
   input  logic               rst,
   spi16_master_tx_if.master  bus
);
   localparam int HW = $clog2(CLK_DIV + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [HW-1:0] HALF = HW'(CLK_DIV);
   localparam logic [GW-1:0] GAPN = GW'(CS_GAP);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

   state_t         state;
   logic [HW-1:0]  hcnt;
   logic [GW-1:0]  gcnt;
   logic [4:0]     bit_cnt;
   logic [15:0]    tx_sh;

`ifdef SPI16_MASTER_TX_RX_EN
   logic [15:0]    rx_sh;
   logic [15:0]    rx_q;
   assign bus.rx_data = rx_q;
`else
   assign bus.rx_data = 16'h0000;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         hcnt         <= '0;
         gcnt         <= '0;
         bit_cnt      <= '0;
         tx_sh        <= '0;
         bus.tx_ready <= 1'b1;
         bus.busy     <= 1'b0;
         bus.spi_cs   <= 1'b1;
         bus.spi_sck  <= 1'b0;
         bus.spi_mosi <= 1'b0;
         bus.rx_valid <= 1'b0;
`ifdef SPI16_MASTER_TX_RX_EN
         rx_sh        <= '0;
         rx_q         <= '0;
`endif
      end else begin
         bus.rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.tx_valid) begin
                  tx_sh        <= bus.tx_data;
                  bus.tx_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  hcnt         <= '0;
                  state        <= LEAD;
               end
            end
            LEAD: begin
               // First LEAD cycle only drops cs; the CLK_DIV low phase starts after it.
               if (bus.spi_cs) begin
                  bus.spi_cs   <= 1'b0;
                  bus.spi_mosi <= tx_sh[15];
                  hcnt         <= HW'(1);
               end else if (hcnt == HALF) begin
                  bus.spi_sck <= 1'b1;
                  hcnt        <= HW'(1);
                  bit_cnt     <= 5'd0;
`ifdef SPI16_MASTER_TX_RX_EN
                  rx_sh       <= {rx_sh[14:0], bus.spi_miso};
`endif
                  state       <= SHIFT;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            SHIFT: begin
               if (hcnt != HALF) begin
                  hcnt <= hcnt + 1'b1;
               end else begin
                  hcnt <= HW'(1);
                  if (bus.spi_sck) begin
                     bus.spi_sck <= 1'b0;
                     bit_cnt     <= bit_cnt + 5'd1;
                     if (bit_cnt != 5'd15) begin
                        tx_sh        <= {tx_sh[14:0], 1'b0};
                        bus.spi_mosi <= tx_sh[14];
                     end
                  end else if (bit_cnt == 5'd16) begin
                     state <= TRAIL;
                  end else begin
                     bus.spi_sck <= 1'b1;
`ifdef SPI16_MASTER_TX_RX_EN
                     rx_sh       <= {rx_sh[14:0], bus.spi_miso};
`endif
                  end
               end
            end
            TRAIL: begin
               if (hcnt == HALF) begin
                  bus.spi_cs   <= 1'b1;
                  bus.spi_mosi <= 1'b0;
                  bus.rx_valid <= 1'b1;
`ifdef SPI16_MASTER_TX_RX_EN
                  rx_q         <= rx_sh;
`endif
                  gcnt         <= GW'(1);
                  state        <= GAP;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            GAP: begin
               if (gcnt == GAPN) begin
                  bus.tx_ready <= 1'b1;
                  bus.busy     <= 1'b0;
                  state        <= IDLE;
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi16_master_tx.sv
// Bench for spi16_master_tx: two instances (CLK_DIV=12/CS_GAP=8 and 1/1) with a bus-level
// responder/monitor that rebuilds each cs window from the pins.
module tb_spi16_master_tx;
   localparam int D_A = 12, G_A = 8, D_B = 1, G_B = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_v[2];
   logic        txv[2];
   logic [15:0] txd[2];
   logic        miso_v[2];
   logic        cs_v[2], sck_v[2], mosi_v[2], rdy_v[2], busy_v[2], rv_v[2];
   logic [15:0] rxd_v[2];

   spi16_master_tx_if ifa();
   spi16_master_tx_if ifb();

   assign ifa.tx_valid = txv[0];  assign ifa.tx_data = txd[0];  assign ifa.spi_miso = miso_v[0];
   assign ifb.tx_valid = txv[1];  assign ifb.tx_data = txd[1];  assign ifb.spi_miso = miso_v[1];
   assign cs_v[0] = ifa.spi_cs;   assign sck_v[0] = ifa.spi_sck;  assign mosi_v[0] = ifa.spi_mosi;
   assign rdy_v[0] = ifa.tx_ready; assign busy_v[0] = ifa.busy;  assign rv_v[0] = ifa.rx_valid;
   assign rxd_v[0] = ifa.rx_data;
   assign cs_v[1] = ifb.spi_cs;   assign sck_v[1] = ifb.spi_sck;  assign mosi_v[1] = ifb.spi_mosi;
   assign rdy_v[1] = ifb.tx_ready; assign busy_v[1] = ifb.busy;  assign rv_v[1] = ifb.rx_valid;
   assign rxd_v[1] = ifb.rx_data;

   spi16_master_tx #(.CLK_DIV(D_A), .CS_GAP(G_A)) dut_a (.clk(clk), .rst(rst_v[0]), .bus(ifa));
   spi16_master_tx #(.CLK_DIV(D_B), .CS_GAP(G_B)) dut_b (.clk(clk), .rst(rst_v[1]), .bus(ifb));

   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? D_A : D_B;
   endfunction

   function automatic logic [15:0] exp_rx(input logic [15:0] resp);
`ifdef SPI16_MASTER_TX_RX_EN
      return resp;
`else
      return 16'h0000;
`endif
   endfunction

   // Scoreboard: words the bench handed over, and the pin-level monitor state per instance.
   logic [15:0] exp_w[2][64];
   int          exp_wr[2], exp_rd[2];
   int          cs_len[2], rises[2], since[2], gap_len[2], last_gap[2];
   int          rdy_run[2], last_rdy_run[2], windows[2], pulses[2], rv_hi[2];
   logic [15:0] mword[2], resp_cur[2], resp_fix[2];
   bit          fix_en[2], spc_bad[2], busy_bad[2];
   logic        p_cs[2], p_sck[2], p_rv[2];

   task automatic window_end(input int i);
      bit have;
      have = (exp_rd[i] < exp_wr[i]);
      check("window_expected", {31'd0, have}, 32'd1);
      if (have) begin
         check("mosi_word", {16'd0, mword[i]}, {16'd0, exp_w[i][exp_rd[i]]});
         exp_rd[i]++;
      end
      check("sck_rises", rises[i], 16);
      check("cs_low_len", cs_len[i], 34 * div_of(i));
      check("rx_valid_at_cs_rise", {31'd0, rv_v[i]}, 32'd1);
      check("rx_data", {16'd0, rxd_v[i]}, {16'd0, exp_rx(resp_cur[i])});
      check("sck_period", {31'd0, spc_bad[i]}, 32'd0);
      check("busy_in_window", {31'd0, busy_bad[i]}, 32'd0);
      check("mosi_after_word", {31'd0, mosi_v[i]}, 32'd0);
      windows[i]++;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_v[i]) begin
            rises[i] = 0; cs_len[i] = 0; p_cs[i] = 1'b1; p_sck[i] = 1'b0;
            p_rv[i] = 1'b0; miso_v[i] = 1'b0; rdy_run[i] = 0;
         end else begin
            if (!cs_v[i]) begin
               if (p_cs[i]) begin
                  last_gap[i] = gap_len[i];
                  cs_len[i] = 0; rises[i] = 0; mword[i] = 16'h0;
                  spc_bad[i] = 1'b0; busy_bad[i] = 1'b0;
                  resp_cur[i] = fix_en[i] ? resp_fix[i] : 16'($urandom);
               end
               cs_len[i]++;
               if (!busy_v[i]) busy_bad[i] = 1'b1;
               if (sck_v[i] && !p_sck[i]) begin
                  if (rises[i] > 0 && since[i] != 2 * div_of(i)) spc_bad[i] = 1'b1;
                  mword[i] = {mword[i][14:0], mosi_v[i]};
                  rises[i]++;
                  since[i] = 0;
               end
               since[i]++;
               // Mode-0 responder: next bit presented once the previous one was sampled.
               miso_v[i] = (rises[i] < 16) ? resp_cur[i][15 - rises[i]] : 1'b0;
            end else begin
               if (!p_cs[i]) begin
                  window_end(i);
                  gap_len[i] = 0;
               end
               gap_len[i]++;
               miso_v[i] = 1'b0;
            end
            if (rv_v[i]) begin
               rv_hi[i]++;
               if (!p_rv[i]) pulses[i]++;
            end
            if (rdy_v[i]) rdy_run[i]++;
            else begin
               if (rdy_run[i] > 0) last_rdy_run[i] = rdy_run[i];
               rdy_run[i] = 0;
            end
            p_cs[i] = cs_v[i]; p_sck[i] = sck_v[i]; p_rv[i] = rv_v[i];
         end
      end
   end

   // Present a word and wait for the handshake; hold keeps tx_valid high for a follow-on word.
   task automatic send(input int i, input logic [15:0] w, input bit hold);
      int n = 0;
      txv[i] = 1'b1;
      txd[i] = w;
      while (!rdy_v[i] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", {31'd0, rdy_v[i]}, 32'd1);
      exp_w[i][exp_wr[i]] = w;
      exp_wr[i]++;
      @(negedge clk);
      if (!hold) txv[i] = 1'b0;
   endtask

   task automatic wait_drain(input int i);
      int n = 0;
      while (exp_rd[i] < exp_wr[i] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_wait", exp_wr[i] - exp_rd[i], 0);
   endtask

   initial begin
      int n;
      int aborted_a;
      aborted_a = 0;
      for (int i = 0; i < 2; i++) begin
         rst_v[i] = 1'b0; txv[i] = 1'b0; txd[i] = 16'h0; fix_en[i] = 1'b0; resp_fix[i] = 16'h0;
         exp_wr[i] = 0; exp_rd[i] = 0; windows[i] = 0; pulses[i] = 0; rv_hi[i] = 0;
         gap_len[i] = 0; last_gap[i] = 0; rdy_run[i] = 0; last_rdy_run[i] = 0; since[i] = 0;
         resp_cur[i] = 16'h0; mword[i] = 16'h0;
      end
      #1;
      rst_v[0] = 1'b1;
      rst_v[1] = 1'b1;
      #2;
      check("rst_tx_ready", {31'd0, rdy_v[0]}, 32'd1);
      check("rst_busy", {31'd0, busy_v[0]}, 32'd0);
      check("rst_cs", {31'd0, cs_v[0]}, 32'd1);
      check("rst_sck", {31'd0, sck_v[0]}, 32'd0);
      check("rst_mosi", {31'd0, mosi_v[0]}, 32'd0);
      check("rst_rx_valid", {31'd0, rv_v[0]}, 32'd0);
      check("rst_rx_data", {16'd0, rxd_v[0]}, 32'd0);
      check("rst_cs_b", {31'd0, cs_v[1]}, 32'd1);
      repeat (3) @(negedge clk);
      #2;
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      @(negedge clk);

      // Single word at CLK_DIV=12.
      send(0, 16'hA5C3, 1'b0);
      wait_drain(0);

      // Known responder word.
      resp_fix[0] = 16'h3C5A;
      fix_en[0] = 1'b1;
      send(0, 16'h5AA5, 1'b0);
      wait_drain(0);
      fix_en[0] = 1'b0;
      check("rx_data_hold", {16'd0, rxd_v[0]}, {16'd0, exp_rx(16'h3C5A)});

      // Back-to-back with tx_valid held: cs high between windows spans the
      // accept-to-accept minimum less the 34*CLK_DIV window, i.e. CS_GAP+2.
      send(0, 16'h0001, 1'b1);
      send(0, 16'hFFFF, 1'b0);
      wait_drain(0);
      check("b2b_cs_gap", last_gap[0], G_A + 2);
      check("b2b_ready_run", last_rdy_run[0], 1);

      // Reset after the 7th rising sck edge.
      send(0, 16'($urandom), 1'b0);
      n = 0;
      while (rises[0] < 7 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_7th_edge", {31'd0, rises[0] >= 7}, 32'd1);
      #2;
      rst_v[0] = 1'b1;
      aborted_a++;
      exp_rd[0]++;
      #1;
      check("abort_cs", {31'd0, cs_v[0]}, 32'd1);
      check("abort_sck", {31'd0, sck_v[0]}, 32'd0);
      check("abort_mosi", {31'd0, mosi_v[0]}, 32'd0);
      check("abort_tx_ready", {31'd0, rdy_v[0]}, 32'd1);
      check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      repeat (2) @(negedge clk);
      #2;
      rst_v[0] = 1'b0;
      @(negedge clk);
      check("idle_after_release", {31'd0, rdy_v[0]}, 32'd1);
      send(0, 16'hC0DE, 1'b0);
      wait_drain(0);

      // CLK_DIV=1, CS_GAP=1.
      send(1, 16'h8001, 1'b0);
      wait_drain(1);

      // tx_valid pulse while busy is ignored.
      send(0, 16'h6B2E, 1'b0);
      repeat (50) @(negedge clk);
      txv[0] = 1'b1;
      txd[0] = 16'h1234;
      @(negedge clk);
      txv[0] = 1'b0;
      check("busy_after_pulse", {31'd0, busy_v[0]}, 32'd1);
      wait_drain(0);
      repeat (34 * D_A + G_A + 20) @(negedge clk);
      check("no_extra_window", windows[0], exp_wr[0] - aborted_a);
      check("ready_after_ignore", {31'd0, rdy_v[0]}, 32'd1);

      // Randomized words on both instances, with random idle gaps and back-to-back runs.
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(0, 15)) @(negedge clk);
         send(0, 16'($urandom), 1'b0);
      end
      wait_drain(0);
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 6)) @(negedge clk);
         send(1, 16'($urandom), (k < 11) && ($urandom_range(0, 1) == 1));
      end
      wait_drain(1);
      repeat (4) @(negedge clk);

      check("windows_a", windows[0], exp_wr[0] - aborted_a);
      check("windows_b", windows[1], exp_wr[1]);
      check("rx_pulses_a", pulses[0], windows[0]);
      check("rx_pulses_b", pulses[1], windows[1]);
      check("rx_width_a", rv_hi[0], pulses[0]);
      check("rx_width_b", rv_hi[1], pulses[1]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
